// File: rtl/pc_steer_unit.sv
// pc_steer_unit: owns the fetch PC, picks next PC (EX mispredict > JAL/JALR > stall hold > predictor),
// raises IF/ID + ID/EX flushes on redirects and carries the fetch prediction tag IF->ID->EX.
// Redirect reaches IMEM 1 clock after assertion. Optional perf counters: define PC_STEER_PERF_EN.
module pc_steer_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] IF_next_PC,
  input  logic [31:0] EX_next_PC,
  input  logic        Predict_Flush,
  input  logic        jalr_valid,
  input  logic [31:0] jalr_target,
  input  logic        stall,
  output logic [31:0] PC,
  output logic [29:0] IF_PC_w,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        ex_pred_taken,
  output logic        redirect_err
`ifdef PC_STEER_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_redirects,
  output logic [CNT_W-1:0] perf_flush_cycles,
  output logic [CNT_W-1:0] perf_stall_cycles
`endif
);

  // A zero-width counter makes no sense; reject it at elaboration.
  if (CNT_W < 1) begin : g_cnt_w_chk
    $error("pc_steer_unit: CNT_W must be at least 1");
  end

  // BOOT is a one-cycle bubble after reset: PC is held so RESET_PC is fetched
  // into a clean IF/ID; RECOVER marks the cycle after a redirect (refilled slots).
  localparam logic [1:0] ST_BOOT    = 2'b00;
  localparam logic [1:0] ST_RUN     = 2'b01;
  localparam logic [1:0] ST_RECOVER = 2'b10;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pt_id_q, pt_id_d;
  logic        pt_ex_q, pt_ex_d;
  logic        err_q, err_d;

  logic        in_boot;
  logic        redirect;
  logic        flush;
  logic        pt_if;
  logic [31:0] redir_tgt;

  assign in_boot   = (state_q == ST_BOOT);
  assign redirect  = Predict_Flush | jalr_valid;
  // EX mispredict correction outranks a JAL/JALR in the same cycle.
  assign redir_tgt = Predict_Flush ? EX_next_PC : jalr_target;
  assign flush     = in_boot | redirect;
  // Fetch "guessed taken" whenever the predictor steers anywhere but the fall-through.
  assign pt_if     = (IF_next_PC != (pc_q + 32'd4));

  assign PC            = pc_q;
  assign IF_PC_w       = pc_q[31:2];
  assign flush_ifid    = flush;
  assign flush_idex    = flush;
  assign ex_pred_taken = pt_ex_q;
  assign redirect_err  = err_q;

  // Next-PC selection, FSM transition and sticky alignment error.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    err_d   = err_q;
    case (state_q)
      ST_RUN, ST_RECOVER: begin
        state_d = redirect ? ST_RECOVER : ST_RUN;
        if (redirect) begin
          // Misaligned targets are forced to the word below and flagged.
          pc_d = {redir_tgt[31:2], 2'b00};
          if (redir_tgt[1:0] != 2'b00) begin
            err_d = 1'b1;
          end
        end else if (!stall) begin
          pc_d = IF_next_PC;
        end
      end
      default: begin
        // BOOT (or any illegal encoding): hold PC, ignore redirects, go run.
        state_d = ST_RUN;
      end
    endcase
  end

  // Prediction tag pipe: flush clears, stall holds ID and bubbles EX.
  always_comb begin
    pt_id_d = pt_id_q;
    pt_ex_d = pt_ex_q;
    if (flush) begin
      pt_id_d = 1'b0;
      pt_ex_d = 1'b0;
    end else if (stall) begin
      pt_ex_d = 1'b0;
    end else begin
      pt_id_d = pt_if;
      pt_ex_d = pt_id_q;
    end
  end

  // State registers; async reset drops back to BOOT from anywhere.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      pt_id_q <= 1'b0;
      pt_ex_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pt_id_q <= pt_id_d;
      pt_ex_q <= pt_ex_d;
      err_q   <= err_d;
    end
  end

`ifdef PC_STEER_PERF_EN
  logic [CNT_W-1:0] perf_red_q;
  logic [CNT_W-1:0] perf_flush_q;
  logic [CNT_W-1:0] perf_stall_q;

  assign perf_redirects    = perf_red_q;
  assign perf_flush_cycles = perf_flush_q;
  assign perf_stall_cycles = perf_stall_q;

  // Saturating event counters: redirect requests, flush cycles, stall cycles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_red_q   <= '0;
      perf_flush_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (redirect && (perf_red_q != '1)) begin
        perf_red_q <= perf_red_q + CNT_W'(1);
      end
      if (flush && (perf_flush_q != '1)) begin
        perf_flush_q <= perf_flush_q + CNT_W'(1);
      end
      if (stall && (perf_stall_q != '1)) begin
        perf_stall_q <= perf_stall_q + CNT_W'(1);
      end
    end
  end
`endif

endmodule
